// File: rtl/midi_uart_tx.sv
// midi_uart_tx
// -----------------------------------------------------------------------------
// MIDI transmit path. Accepts one message (status, data1, data2) per handshake
// and sends it as 8N1 UART bytes, LSB first, at BAUD bits per second. The number
// of bytes sent is decoded from the status byte. Data bytes always go out with
// bit7 cleared. A status without bit7 set is dropped without any line activity.
//
// Handshake: a message is accepted on a rising edge where msg_valid & msg_ready.
// The producer holds msg_valid and the three bytes stable until then. msg_ready
// is combinational: (state == IDLE) & en & ~rst. The bytes are captured at
// acceptance, so the producer may change them afterwards.
//
// Optional feature (macro MIDI_RUNNING_STATUS_EN): MIDI running status. A
// channel message whose status equals the last sent channel status is sent
// without its status byte. System common statuses 0xF0-0xF7 clear the
// remembered status. Real-time statuses 0xF8-0xFF and dropped messages leave it
// unchanged. If the macro is undefined, every message carries its status byte.
//
// Parameters: CLK_HZ system clock in Hz, BAUD bit rate. CLK_HZ/BAUD must be an
//             integer of at least 2.
// Ports:
//   MHz10      in   system clock, rising edge
//   rst        in   synchronous reset, active high
//   en         in   allows new messages to be accepted
//   msg_status in   [7:0] MIDI status byte
//   msg_data1  in   [7:0] first data byte
//   msg_data2  in   [7:0] second data byte
//   msg_valid  in   message present
//   msg_ready  out  a message can be accepted this cycle
//   serOut     out  registered UART line, idle high
//   busy       out  a message is being serialized
//   byte_done  out  one-cycle pulse in the last cycle of each stop bit
// -----------------------------------------------------------------------------
module midi_uart_tx #(
    parameter int CLK_HZ = 10_000_000,
    parameter int BAUD   = 31_250
) (
    input  logic       MHz10,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] msg_status,
    input  logic [7:0] msg_data1,
    input  logic [7:0] msg_data2,
    input  logic       msg_valid,
    output logic       msg_ready,
    output logic       serOut,
    output logic       busy,
    output logic       byte_done
);

    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_n;

    logic [CNT_W-1:0] cnt;        // cycles within the current bit
    logic [2:0]       bit_cnt;    // data bit being sent
    logic [1:0]       idx;        // byte of the message being sent: 0 status, 1 data1, 2 data2
    logic [1:0]       last_idx;   // final byte index for the latched status
    logic [1:0]       first_idx;  // first byte index chosen at acceptance
    logic [7:0]       stat_q;
    logic [7:0]       d1_q;
    logic [7:0]       d2_q;
    logic [7:0]       shreg;
    logic             line_n;
    logic             done_n;
    logic             bit_end;
    logic             accept;
    logic             drop;

    assign msg_ready = (state == IDLE) & en & ~rst;
    assign accept    = msg_valid & msg_ready;
    assign busy      = (state != IDLE);
    assign bit_end   = (cnt == CNT_LAST);
    assign drop      = ~stat_q[7];

    // Last byte index from the status high nibble. Dropped statuses never
    // reach a byte, so their value here does not matter.
    always_comb begin
        last_idx = 2'd2;
        case (stat_q[7:4])
            4'hC, 4'hD: last_idx = 2'd1;
            4'hF:       last_idx = 2'd0;
            default:    last_idx = 2'd2;
        endcase
    end

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] last_status;

    // Skip the status byte when a channel status repeats the previous one.
    always_comb begin
        first_idx = 2'd0;
        if (msg_status[7] && (msg_status[7:4] != 4'hF) && (msg_status == last_status))
            first_idx = 2'd1;
    end

    always_ff @(posedge MHz10) begin
        if (rst) begin
            last_status <= 8'h00;
        end else if (accept && msg_status[7]) begin
            if (msg_status[7:4] != 4'hF)
                last_status <= msg_status;
            else if (!msg_status[3])
                last_status <= 8'h00;
        end
    end
`else
    assign first_idx = 2'd0;
`endif

    // State register
    always_ff @(posedge MHz10) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next state and the line level / byte_done value for the coming cycle.
    // Both are registered below, so the line lags the state by one cycle.
    always_comb begin
        state_n = state;
        line_n  = 1'b1;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (accept)
                    state_n = LOAD;
            end
            LOAD: begin
                state_n = drop ? IDLE : START;
            end
            START: begin
                line_n = 1'b0;
                if (bit_end)
                    state_n = DATA;
            end
            DATA: begin
                line_n = shreg[0];
                if (bit_end && (bit_cnt == 3'd7))
                    state_n = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    done_n  = 1'b1;
                    state_n = (idx == last_idx) ? IDLE : LOAD;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: baud counter, message registers, shift register, outputs
    always_ff @(posedge MHz10) begin
        if (rst) begin
            cnt       <= '0;
            bit_cnt   <= 3'd0;
            idx       <= 2'd0;
            stat_q    <= 8'h00;
            d1_q      <= 8'h00;
            d2_q      <= 8'h00;
            shreg     <= 8'h00;
            serOut    <= 1'b1;
            byte_done <= 1'b0;
        end else begin
            serOut    <= line_n;
            byte_done <= done_n;

            // Counter restarts on every state entry and at each bit boundary
            if ((state_n != state) || bit_end ||
                (state == IDLE) || (state == LOAD))
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);

            if (accept) begin
                stat_q <= msg_status;
                d1_q   <= msg_data1 & 8'h7F;
                d2_q   <= msg_data2 & 8'h7F;
                idx    <= first_idx;
            end

            if (state == LOAD) begin
                bit_cnt <= 3'd0;
                case (idx)
                    2'd1:    shreg <= d1_q;
                    2'd2:    shreg <= d2_q;
                    default: shreg <= stat_q;
                endcase
            end

            if ((state == DATA) && bit_end) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end

            if ((state == STOP) && bit_end && (idx != last_idx))
                idx <= idx + 2'd1;
        end
    end

endmodule

// File: tb/tb_midi_uart_tx.sv
`timescale 1ns/1ps
module tb_midi_uart_tx;

    localparam int BIT = 320;
    localparam int BYTE_CYC = 10 * BIT + 1;   // frame plus one LOAD cycle
`ifdef MIDI_RUNNING_STATUS_EN
    localparam int N_RAND = 1;
`else
    localparam int N_RAND = 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] msg_status;
    logic [7:0] msg_data1;
    logic [7:0] msg_data2;
    logic       msg_valid;
    logic       msg_ready;
    logic       serOut;
    logic       busy;
    logic       byte_done;

    int total = 0;
    int bad = 0;

    logic [7:0] exp_q[$];
    logic [7:0] m_last = 8'h00;

    midi_uart_tx dut (
        .MHz10      (clk),
        .rst        (rst),
        .en         (en),
        .msg_status (msg_status),
        .msg_data1  (msg_data1),
        .msg_data2  (msg_data2),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .serOut     (serOut),
        .busy       (busy),
        .byte_done  (byte_done)
    );

    // ---------------- clock / watchdog ----------------
    always #50 clk = ~clk;

    initial begin
        #(64'd110_000 * 64'd100);
        bad++;
        $display("FAIL watchdog: simulation did not finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: which bytes a message produces on the line
    task automatic model_push(input logic [7:0] s, input logic [7:0] d1,
                              input logic [7:0] d2, output int n);
        int nd;
        logic with_status;
        n = 0;
        if (s >= 8'hF0) begin
            exp_q.push_back(s);
            n = 1;
`ifdef MIDI_RUNNING_STATUS_EN
            if (s <= 8'hF7) m_last = 8'h00;
`endif
        end else if (s >= 8'h80) begin
            nd = (s >= 8'hC0 && s <= 8'hDF) ? 1 : 2;
            with_status = 1'b1;
`ifdef MIDI_RUNNING_STATUS_EN
            with_status = (s != m_last);
            m_last = s;
`endif
            if (with_status) begin
                exp_q.push_back(s);
                n++;
            end
            exp_q.push_back(d1 % 8'd128);
            n++;
            if (nd == 2) begin
                exp_q.push_back(d2 % 8'd128);
                n++;
            end
        end
    endtask

    // Present a message, wait for acceptance, push expectation
    task automatic send(input logic [7:0] s, input logic [7:0] d1,
                        input logic [7:0] d2, output int n);
        int k;
        n = 0;
        @(negedge clk);
        msg_status = s;
        msg_data1  = d1;
        msg_data2  = d2;
        msg_valid  = 1'b1;
        k = 0;
        while (!msg_ready && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (!msg_ready) begin
            chk("accept_timeout", 32'(msg_ready), 32'd1);
            msg_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_push(s, d1, d2, n);
            #1;
            msg_valid  = 1'b0;
            msg_status = 8'($urandom);
            msg_data1  = 8'($urandom);
            msg_data2  = 8'($urandom);
        end
    endtask

    // Called right after acceptance: count busy cycles and byte_done pulses
    task automatic measure(input string name, input int exp_bytes,
                           output logic s1, output logic s2);
        int bc;
        int dc;
        int k;
        bc = 0;
        dc = 0;
        k = 0;
        s1 = 1'bx;
        s2 = 1'bx;
        forever begin
            @(negedge clk);
            k++;
            dc += int'(byte_done);
            if (!busy || k > 20000) break;
            bc++;
            if (bc == 2) s1 = serOut;
            if (bc == 3) s2 = serOut;
        end
        chk({name, "_busy_cycles"}, 32'(bc), 32'(exp_bytes * BYTE_CYC));
        chk({name, "_byte_done"}, 32'(dc), 32'(exp_bytes));
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic prev;
        logic [9:0] bits;
        logic shape_ok;
        logic aborted;
        logic [7:0] e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b1;
            end else if (prev && !serOut) begin
                bits = '0;
                shape_ok = 1'b1;
                aborted = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < BIT; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (c == 0) bits[b] = serOut;
                        else if (serOut !== bits[b]) shape_ok = 1'b0;
                        if (byte_done !== ((b == 9 && c == BIT - 1) ? 1'b1 : 1'b0))
                            shape_ok = 1'b0;
                    end
                    if (aborted) break;
                end
                if (!aborted) begin
                    chk("frame_shape", {29'd0, shape_ok, bits[0], bits[9]}, 32'b101);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_byte: got %0h expected no byte", bits[8:1]);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rx_byte", 32'(bits[8:1]), 32'(e));
                    end
                end
                prev = rst ? 1'b1 : serOut;
            end else begin
                prev = serOut;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int k;
        logic s1;
        logic s2;
        logic idle_ok;
        logic [7:0] rs;
        logic [7:0] prev_s;

        rst = 1'b1;
        en = 1'b1;
        msg_valid = 1'b0;
        msg_status = 8'h00;
        msg_data1 = 8'h00;
        msg_data2 = 8'h00;

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("ready_in_reset", 32'(msg_ready), 32'd0);
        chk("reset_outputs", {29'd0, serOut, busy, byte_done}, 32'b100);
        rst = 1'b0;
        en = 1'b0;
        idle_ok = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (serOut !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
        end
        chk("idle_1000", 32'(idle_ok), 32'd1);
        chk("ready_en_low", 32'(msg_ready), 32'd0);
        en = 1'b1;
        #1;
        chk("ready_en_high", 32'(msg_ready), 32'd1);
        en = 1'b0;
        #1;
        chk("ready_drops_with_en", 32'(msg_ready), 32'd0);
        en = 1'b1;

        // Note-on, three bytes, with start-edge latency
        send(8'h90, 8'h3C, 8'h64, n);
        measure("note_on", 3, s1, s2);
        chk("line_high_before_start", 32'(s1), 32'd1);
        chk("start_edge_latency", 32'(s2), 32'd0);

        // Program change: two bytes; then a dropped message
        send(8'hC2, 8'h05, 8'hAA, n);
        measure("prog_change", 2, s1, s2);
        send(8'h35, 8'h00, 8'h00, n);
        chk("drop_model_bytes", 32'(n), 32'd0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!msg_ready && k < 2);
        chk("drop_ready_back", 32'(msg_ready), 32'd1);
        chk("drop_line_idle", 32'(serOut), 32'd1);

        // Data bit7 masking, then a real-time byte
        send(8'h80, 8'hC0, 8'hFF, n);
        measure("note_off_mask", 3, s1, s2);
        send(8'hF8, 8'h12, 8'h34, n);
        measure("realtime", 1, s1, s2);

        // Reset in the middle of the second byte
        send(8'h90, 8'h3C, 8'h64, n);
        repeat (BYTE_CYC + 1300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", {28'd0, serOut, busy, byte_done, msg_ready}, 32'b1000);
        exp_q.delete();
        m_last = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        send(8'h90, 8'h3C, 8'h64, n);
        measure("after_reset", 3, s1, s2);

`ifdef MIDI_RUNNING_STATUS_EN
        // Running status: 0x90 was just sent in full after reset
        send(8'h90, 8'h3E, 8'h64, n);
        measure("rs_repeat", 2, s1, s2);
        send(8'hF8, 8'h00, 8'h00, n);
        measure("rs_realtime", 1, s1, s2);
        send(8'h90, 8'h40, 8'h10, n);
        measure("rs_after_rt", 2, s1, s2);
        send(8'hF0, 8'h00, 8'h00, n);
        measure("rs_sysex", 1, s1, s2);
        send(8'h90, 8'h40, 8'h10, n);
        measure("rs_after_clear", 3, s1, s2);
`endif

        // Randomized messages; some back to back, some with en dropped mid-message
        prev_s = 8'h90;
        for (int i = 0; i < N_RAND; i++) begin
            case ($urandom_range(0, 4))
                0: rs = 8'($urandom_range(128, 239));
                1: rs = 8'($urandom_range(240, 255));
                2: rs = 8'($urandom_range(0, 127));
                3: rs = 8'($urandom_range(192, 223));
                default: rs = prev_s;
            endcase
            if (rs[7] && rs < 8'hF0) prev_s = rs;
            send(rs, 8'($urandom), 8'($urandom), n);
            en = 1'($urandom_range(0, 1));
            if (n != 0 && $urandom_range(0, 1) == 1) measure("random", n, s1, s2);
            repeat ($urandom_range(0, 300)) @(negedge clk);
            en = 1'b1;
        end

        // Drain
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/midi_uart_tx.md
Name: midi_uart_tx

Overview:
- MIDI transmit path: takes one channel/system message (status, data1, data2) per handshake and sends it as 8N1 UART bytes at 31250 baud.
- Mirror of the synth's UART/MIDI receive path.
- Used to echo or forward note/controller events to an external MIDI device, and as a loopback stimulus source for the receive chain.

Parameters:
- CLK_HZ, 10000000, system clock frequency in Hz.
- BAUD, 31250, serial bit rate. Bit period BIT_CYC = CLK_HZ/BAUD = 320 clocks at defaults; must divide exactly.

Ports:
- MHz10  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- en  input  1  enable for message acceptance; a message in flight always completes
- msg_status  input  8  MIDI status byte
- msg_data1  input  8  first data byte (note / controller number)
- msg_data2  input  8  second data byte (velocity / value)
- msg_valid  input  1  message present; held with stable bytes until accepted
- msg_ready  output  1  block can accept a message this cycle
- serOut  output  1  UART line, idle high
- busy  output  1  a message is being serialized
- byte_done  output  1  one-cycle pulse at the end of each stop bit

Behaviour:
- Reset values: serOut=1, msg_ready=0 in the reset cycle, busy=0, byte_done=0, baud counter=0, FSM=IDLE.
- msg_ready = (state==IDLE) & en & ~rst. Acceptance occurs when msg_valid & msg_ready.
- On acceptance, the three bytes are latched into internal registers. Input changes after acceptance are ignored.
- Byte count is decoded from the latched status:
  - 0x8n/0x9n/0xAn/0xBn/0xEn → 3 bytes.
  - 0xCn/0xDn → 2 bytes.
  - 0xF0–0xFF → 1 byte (status only).
  - bit7=0 → message is dropped: no line activity, FSM returns to IDLE the next cycle.
- Data bytes are sent with bit7 forced to 0.
- FSM states: IDLE → LOAD (1 cycle; selects the next byte) → START (BIT_CYC cycles, serOut=0) → DATA (8×BIT_CYC cycles, LSB first) → STOP (BIT_CYC cycles, serOut=1).
  - At the end of STOP: byte_done pulses. If bytes remain, go to LOAD; otherwise go to IDLE.
- Latency: the falling edge of the start bit appears 2 cycles after the acceptance edge (LOAD, then START registered).
- Byte spacing: consecutive bytes of one message are separated by exactly 1 extra cycle (LOAD). At 10 MHz a 3-byte message occupies 3×3200+3 cycles. serOut is registered and glitch-free.
- busy=1 from the cycle after acceptance through the last STOP cycle.
- A new message may be accepted the cycle after return to IDLE.
- The baud counter counts 0..BIT_CYC-1 and is reset to 0 on every state entry.
- en deasserted mid-message: the current message finishes. en deasserted in IDLE: msg_ready drops the same cycle.
- rst asserted at any time (including mid-bit): next edge forces the reset values and serOut=1. The partial frame is abandoned.
- msg_valid asserted during rst or while busy is not accepted; it stays pending until msg_ready.

Optional Feature:
- Macro: MIDI_RUNNING_STATUS_EN.
- Defined:
  - A last_status register (reset 0x00) records each transmitted status 0x80–0xEF.
  - A channel message whose status equals last_status is sent without its status byte: 2 or 1 data bytes only.
  - Any 0xF0–0xF7 status clears last_status to 0x00.
  - 0xF8–0xFF (real-time) leaves last_status unchanged.
  - Dropped messages leave last_status unchanged.
- Undefined: every message carries its status byte; no last_status register exists.

Test Plan:
- Reset then idle: serOut=1 and busy=0 for 1000 cycles; msg_ready=1 once en=1.
- Send 0x90,0x3C,0x64 → bytes 0x90,0x3C,0x64. Each frame is start 0, LSB-first data, stop 1, each bit 320 cycles. Start edge is 2 cycles after accept, total 9603 cycles busy, 3 byte_done pulses.
- Send 0xC2,0x05,0xAA → only 0xC2,0x05 transmitted. Then send 0x35,0x00,0x00 → dropped: no line activity, msg_ready back the next cycle.
- Send 0x80,0xC0,0xFF → data transmitted as 0x40,0x7F. Then 0xF8 → single byte 0xF8.
- Reset mid-data-bit of the second byte → serOut=1 next cycle, busy=0. A new 0x90 message then transmits cleanly.
- With MIDI_RUNNING_STATUS_EN: send 0x90,0x3C,0x64 then 0x90,0x3E,0x64 → second message is 0x3E,0x64 only. Then 0xF8, then 0x90,0x40,0x10 → 0x40,0x10 (status still omitted). Then 0xF0, then 0x90,0x40,0x10 → full 3 bytes.
